// File: rtl/crc10_frame_checker.sv
// Receive-side CRC-10 (poly 0x233, init 0) frame checker, one 32-bit word per cycle, MSB first.
// Optional saturating error counter on port Err_Cnt when CRC_CHK_ERR_CNT_EN is defined.
module crc10_frame_checker #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             Rst_n,
  input  logic [31:0]      Data_In,
  input  logic             Data_Valid,
  input  logic             Data_Last,
  output logic             Ready,
  input  logic [9:0]       Crc_In,
  input  logic             Crc_Valid,
  output logic             Chk_Done,
  output logic             Chk_Ok,
  output logic [9:0]       Calc_Crc,
  output logic [CNT_W-1:0] Word_Cnt,
  output logic             Ovf_Err
`ifdef CRC_CHK_ERR_CNT_EN
  ,
  output logic [15:0]      Err_Cnt
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, DATA, WAIT_CRC, REPORT} state_t;

  state_t           state_q, state_d;
  logic [9:0]       crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [9:0]       calc_q, calc_d;
  logic             ovf_err_q, ovf_err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             accept;

  function automatic logic [9:0] crc10_word(input logic [9:0] crc_in, input logic [31:0] dat);
    logic [9:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      fb = c[9] ^ dat[i];
      c  = {c[8:0], 1'b0} ^ (fb ? 10'h233 : 10'h000);
    end
    return c;
  endfunction

  assign accept = Data_Valid & ready_q;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    match_d   = match_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    calc_d    = calc_q;
    ovf_err_d = ovf_err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          crc_d   = crc10_word(10'h000, Data_In);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = Data_Last ? WAIT_CRC : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          crc_d = crc10_word(crc_q, Data_In);
          // Count saturates; the frame keeps hashing but is marked bad.
          if (cnt_q == MAX_CNT) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
          if (Data_Last) state_d = WAIT_CRC;
        end
      end
      WAIT_CRC: begin
        if (Crc_Valid) begin
          match_d = (Crc_In == crc_q);
          state_d = REPORT;
        end
      end
      REPORT: begin
        done_d    = 1'b1;
        ok_d      = match_q & ~ovf_q;
        calc_d    = crc_q;
        ovf_err_d = ovf_q;
        if (!ok_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered from next state so Ready drops in the same edge that accepts the last word.
    ready_d = (state_d == IDLE) || (state_d == DATA);
  end

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      crc_q     <= 10'h000;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      match_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      calc_q    <= 10'h000;
      ovf_err_q <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      match_q   <= match_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      calc_q    <= calc_d;
      ovf_err_q <= ovf_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Ready    = ready_q;
  assign Chk_Done = done_q;
  assign Chk_Ok   = ok_q;
  assign Calc_Crc = calc_q;
  assign Word_Cnt = cnt_q;
  assign Ovf_Err  = ovf_err_q;

`ifdef CRC_CHK_ERR_CNT_EN
  assign Err_Cnt = err_cnt_q;
`else
  logic unused_err_cnt;
  assign unused_err_cnt = ^err_cnt_q;
`endif

endmodule

// File: tb/tb_crc10_frame_checker.sv
// Directed bench for crc10_frame_checker with hand-computed CRC-10 expectations.
module tb_crc10_frame_checker;

  localparam int MAX_WORDS = 256;
  localparam int CNT_W     = 16;

  logic             Clock = 1'b0;
  logic             Rst_n = 1'b0;
  logic [31:0]      Data_In = '0;
  logic             Data_Valid = 1'b0;
  logic             Data_Last = 1'b0;
  logic             Ready;
  logic [9:0]       Crc_In = '0;
  logic             Crc_Valid = 1'b0;
  logic             Chk_Done;
  logic             Chk_Ok;
  logic [9:0]       Calc_Crc;
  logic [CNT_W-1:0] Word_Cnt;
  logic             Ovf_Err;
`ifdef CRC_CHK_ERR_CNT_EN
  logic [15:0]      Err_Cnt;
`endif

  int checks = 0;
  int errors = 0;

  crc10_frame_checker #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Rst_n(Rst_n),
    .Data_In(Data_In), .Data_Valid(Data_Valid), .Data_Last(Data_Last), .Ready(Ready),
    .Crc_In(Crc_In), .Crc_Valid(Crc_Valid),
    .Chk_Done(Chk_Done), .Chk_Ok(Chk_Ok), .Calc_Crc(Calc_Crc),
    .Word_Cnt(Word_Cnt), .Ovf_Err(Ovf_Err)
`ifdef CRC_CHK_ERR_CNT_EN
    , .Err_Cnt(Err_Cnt)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    Data_In = d; Data_Valid = 1'b1; Data_Last = last;
    while (!Ready && n < 50) begin
      @(posedge Clock); #1; n++;
    end
    if (n == 50) check("rdy_timeout", {31'b0, Ready}, 32'd1);
    @(posedge Clock); #1;
    Data_Valid = 1'b0; Data_Last = 1'b0;
  endtask

  task automatic send_crc(input logic [9:0] c);
    Crc_In = c; Crc_Valid = 1'b1;
    @(posedge Clock); #1;
    Crc_Valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge Clock);
    while (!Chk_Done && n < 30) begin
      @(negedge Clock); n++;
    end
    if (n == 30) check({tag, "_done_timeout"}, {31'b0, Chk_Done}, 32'd1);
  endtask

  initial begin
    // Reset with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      Data_In = $urandom; Data_Valid = 1'($urandom); Data_Last = 1'($urandom);
      Crc_In = 10'($urandom); Crc_Valid = 1'($urandom);
    end
    @(negedge Clock);
    check("rst_ready", {31'b0, Ready}, 32'd1);
    check("rst_done", {31'b0, Chk_Done}, 32'd0);
    check("rst_ok", {31'b0, Chk_Ok}, 32'd0);
    check("rst_calc", {22'b0, Calc_Crc}, 32'd0);
    check("rst_cnt", {16'b0, Word_Cnt}, 32'd0);
    check("rst_ovf", {31'b0, Ovf_Err}, 32'd0);
`ifdef CRC_CHK_ERR_CNT_EN
    check("rst_errcnt", {16'b0, Err_Cnt}, 32'd0);
`endif
    Data_In = '0; Data_Valid = 1'b0; Data_Last = 1'b0; Crc_In = '0; Crc_Valid = 1'b0;
    Rst_n = 1'b1;
    @(posedge Clock); #1;
    check("rel_ready", {31'b0, Ready}, 32'd1);

    // Single-word pass with exact latency.
    send_word(32'h00000001, 1'b1);
    check("p_rdy_wait", {31'b0, Ready}, 32'd0);
    send_crc(10'h233);
    @(negedge Clock);
    check("p_lat0", {31'b0, Chk_Done}, 32'd0);
    @(negedge Clock);
    check("p_done", {31'b0, Chk_Done}, 32'd1);
    check("p_ok", {31'b0, Chk_Ok}, 32'd1);
    check("p_calc", {22'b0, Calc_Crc}, 32'h233);
    check("p_cnt", {16'b0, Word_Cnt}, 32'd1);
    check("p_ready", {31'b0, Ready}, 32'd1);
    @(negedge Clock);
    check("p_pulse", {31'b0, Chk_Done}, 32'd0);
    check("p_ok_hold", {31'b0, Chk_Ok}, 32'd1);

    // Single-word fail.
    send_word(32'h00000002, 1'b1);
    send_crc(10'h233);
    wait_done("f");
    check("f_ok", {31'b0, Chk_Ok}, 32'd0);
    check("f_calc", {22'b0, Calc_Crc}, 32'h255);
`ifdef CRC_CHK_ERR_CNT_EN
    @(negedge Clock);
    check("f_errcnt", {16'b0, Err_Cnt}, 32'd1);
`endif

    // Four zero words, gap with stray Last and Crc_Valid, Data_Valid in WAIT_CRC.
    send_word(32'h0, 1'b0);
    send_word(32'h0, 1'b0);
    Data_Last = 1'b1; Crc_In = 10'h3FF; Crc_Valid = 1'b1;
    @(posedge Clock); #1;
    Data_Last = 1'b0; Crc_Valid = 1'b0;
    send_word(32'h0, 1'b0);
    Data_In = 32'h0; Data_Valid = 1'b1; Data_Last = 1'b1; Crc_In = 10'h155; Crc_Valid = 1'b1;
    @(posedge Clock); #1;
    Crc_Valid = 1'b0; Data_Last = 1'b0; Data_In = 32'hFFFFFFFF;
    check("m_rdy_wait", {31'b0, Ready}, 32'd0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Data_Valid = 1'b0;
    check("m_cnt_wait", {16'b0, Word_Cnt}, 32'd4);
    send_crc(10'h000);
    wait_done("m");
    check("m_ok", {31'b0, Chk_Ok}, 32'd1);
    check("m_cnt", {16'b0, Word_Cnt}, 32'd4);
    check("m_calc", {22'b0, Calc_Crc}, 32'h000);

    // Overflow: MAX_WORDS+1 zero words.
    for (int i = 0; i < MAX_WORDS; i++) send_word(32'h0, 1'b0);
    send_word(32'h0, 1'b1);
    send_crc(10'h000);
    wait_done("o");
    check("o_ok", {31'b0, Chk_Ok}, 32'd0);
    check("o_ovf", {31'b0, Ovf_Err}, 32'd1);
    check("o_cnt", {16'b0, Word_Cnt}, MAX_WORDS);
    send_word(32'h00000001, 1'b1);
    send_crc(10'h233);
    wait_done("oc");
    check("oc_ok", {31'b0, Chk_Ok}, 32'd1);
    check("oc_ovf", {31'b0, Ovf_Err}, 32'd0);

    // Reset mid-frame.
    send_word(32'h12345678, 1'b0);
    send_word(32'h9ABCDEF0, 1'b0);
    send_word(32'h0F0F0F0F, 1'b0);
    @(negedge Clock);
    Rst_n = 1'b0;
    Crc_In = 10'h000; Crc_Valid = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge Clock);
        if (Chk_Done) seen++;
      end
      check("r_no_done", seen, 32'd0);
    end
    check("r_cnt", {16'b0, Word_Cnt}, 32'd0);
    check("r_ready", {31'b0, Ready}, 32'd1);
    Crc_Valid = 1'b0;
    Rst_n = 1'b1;
    @(posedge Clock); #1;
    send_word(32'h00000001, 1'b1);
    send_crc(10'h233);
    wait_done("r");
    check("r_ok", {31'b0, Chk_Ok}, 32'd1);
    check("r_calc", {22'b0, Calc_Crc}, 32'h233);
    check("r_wcnt", {16'b0, Word_Cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
